// File: rtl/dna_pkg.sv
// Shared types for the DNA alignment traceback slice.
//   dir_t      : direction codes held in the direction memory and emitted as ops.
//   tb_state_t : traceback controller states.
package dna_pkg;

  typedef enum logic [1:0] {
    STOP = 2'b00,
    DIAG = 2'b01,
    UP   = 2'b10,
    LEFT = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EMIT,
    DONE
  } tb_state_t;

endpackage

// File: rtl/dna_traceback_unit_if.sv
// Bus between the traceback unit and its environment (sequencer, direction
// memory, op consumer).
//   traceback_n  : active-low phase enable (low = run traceback)
//   dir_rd_en    : direction-memory read strobe
//   dir_rd_addr  : read address i*(COLS+1)+j
//   dir_rd_data  : direction code, valid one cycle after dir_rd_en
//   op_valid/op_code/op_ready : alignment-op output handshake
//   ftraceback   : phase-done flag
// modport master = traceback unit side, slave = environment side.
interface dna_traceback_unit_if #(
  parameter int ADDR_W = 9
);
  logic              traceback_n;
  logic              dir_rd_en;
  logic [ADDR_W-1:0] dir_rd_addr;
  logic [1:0]        dir_rd_data;
  logic              op_valid;
  logic [1:0]        op_code;
  logic              op_ready;
  logic              ftraceback;

  modport master (
    input  traceback_n, dir_rd_data, op_ready,
    output dir_rd_en, dir_rd_addr, op_valid, op_code, ftraceback
  );

  modport slave (
    output traceback_n, dir_rd_data, op_ready,
    input  dir_rd_en, dir_rd_addr, op_valid, op_code, ftraceback
  );
endinterface

// File: rtl/dna_traceback_unit_stats.sv
// tb_stats_cnt: counts accepted traceback ops per direction.
// Only instantiated when TB_STATS_EN is defined.
//   clk, reset : clock, async active-high reset
//   clr_i      : synchronous clear (start of a traceback)
//   inc_i      : an op was accepted this cycle
//   code_i     : direction of the accepted op
//   n_*_o      : per-direction counts
module tb_stats_cnt
  import dna_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  input  dir_t         code_i,
  output logic [W-1:0] n_diag_o,
  output logic [W-1:0] n_up_o,
  output logic [W-1:0] n_left_o
);
  logic [W-1:0] n_diag_q, n_up_q, n_left_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_diag_q <= '0;
      n_up_q   <= '0;
      n_left_q <= '0;
    end else if (clr_i) begin
      n_diag_q <= '0;
      n_up_q   <= '0;
      n_left_q <= '0;
    end else if (inc_i) begin
      case (code_i)
        DIAG:    n_diag_q <= n_diag_q + 1'b1;
        UP:      n_up_q   <= n_up_q + 1'b1;
        LEFT:    n_left_q <= n_left_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign n_diag_o = n_diag_q;
  assign n_up_o   = n_up_q;
  assign n_left_o = n_left_q;
endmodule

// File: rtl/dna_traceback_unit.sv
// dna_traceback_unit: walks the direction matrix from (ROWS,COLS) back to
// (0,0), reading one direction code per step and emitting one alignment op
// per step (01 diag, 10 up, 11 left). Row 0 forces LEFT, column 0 forces UP.
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : dna_traceback_unit_if.master (phase enable, memory read,
//                op handshake, done flag)
//   n_diag/n_up/n_left : accepted-op counters, present only when
//                TB_STATS_EN is defined.
module dna_traceback_unit
  import dna_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int ADDR_W = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  dna_traceback_unit_if.master      bus
`ifdef TB_STATS_EN
  ,
  output logic [$clog2(ROWS+COLS+1)-1:0] n_diag,
  output logic [$clog2(ROWS+COLS+1)-1:0] n_up,
  output logic [$clog2(ROWS+COLS+1)-1:0] n_left
`endif
);
  localparam int IW = $clog2(ROWS + 2);
  localparam int JW = $clog2(COLS + 2);

  tb_state_t         state_q;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  dir_t              code_q, code_d;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              ftb_q;
  logic              abort;
  logic              hs;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IW-1:0] i,
                                                input logic [JW-1:0] j);
    return ADDR_W'(i) * ADDR_W'(COLS + 1) + ADDR_W'(j);
  endfunction

  assign abort = bus.traceback_n;
  // valid_q is only ever set in EMIT; abort takes priority over acceptance
  assign hs    = valid_q & bus.op_ready & ~abort;

  always_comb begin
    code_d = dir_t'(bus.dir_rd_data);
    if (i_q == '0)      code_d = LEFT;
    else if (j_q == '0) code_d = UP;
    i_d = i_q;
    j_d = j_q;
    case (code_q)
      DIAG: begin
        i_d = i_q - 1'b1;
        j_d = j_q - 1'b1;
      end
      UP:      i_d = i_q - 1'b1;
      LEFT:    j_d = j_q - 1'b1;
      default: ;
    endcase
  end

  // The read strobe is a registered output, so the (0,0) check is made on
  // the transition that would enter READ; reaching (0,0) goes straight to
  // DONE without issuing a read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      code_q  <= STOP;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      ftb_q   <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.traceback_n) begin
            i_q <= IW'(ROWS);
            j_q <= JW'(COLS);
            if (ROWS == 0 && COLS == 0) begin
              state_q <= DONE;
              ftb_q   <= 1'b1;
            end else begin
              state_q <= READ;
              rd_en_q <= 1'b1;
              addr_q  <= addr_of(IW'(ROWS), JW'(COLS));
            end
          end
        end
        READ: state_q <= abort ? IDLE : WAIT;
        WAIT: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (code_d == STOP) begin
            state_q <= DONE;
            ftb_q   <= 1'b1;
          end else begin
            code_q  <= code_d;
            valid_q <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (abort) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else if (hs) begin
            valid_q <= 1'b0;
            i_q     <= i_d;
            j_q     <= j_d;
            if (i_d == '0 && j_d == '0) begin
              state_q <= DONE;
              ftb_q   <= 1'b1;
            end else begin
              state_q <= READ;
              rd_en_q <= 1'b1;
              addr_q  <= addr_of(i_d, j_d);
            end
          end
        end
        DONE: begin
          if (bus.traceback_n) begin
            state_q <= IDLE;
            ftb_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dir_rd_en   = rd_en_q;
  assign bus.dir_rd_addr = addr_q;
  assign bus.op_valid    = valid_q;
  assign bus.op_code     = code_q;
  assign bus.ftraceback  = ftb_q;

`ifdef TB_STATS_EN
  localparam int SW = $clog2(ROWS + COLS + 1);
  tb_stats_cnt #(.W(SW)) u_stats (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == IDLE && !bus.traceback_n),
    .inc_i    (hs),
    .code_i   (code_q),
    .n_diag_o (n_diag),
    .n_up_o   (n_up),
    .n_left_o (n_left)
  );
`endif
endmodule

// File: doc/dna_traceback_unit.md
DNA_TRACEBACK_UNIT -- requirements
Module: dna_traceback_unit

Interface
REQ-001 SHALL have parameter ROWS, default 16: sequence-A length; matrix has ROWS+1 rows.
REQ-002 SHALL have parameter COLS, default 16: sequence-B length; matrix has COLS+1 columns.
REQ-003 SHALL have parameter ADDR_W, default 9: direction-memory address width, >= clog2((ROWS+1)*(COLS+1)).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 traceback_n  input  1  active-low phase enable from the phase sequencer; low = run traceback.
REQ-007 dir_rd_en  output  1  direction-memory read strobe.
REQ-008 dir_rd_addr  output  ADDR_W  read address, i*(COLS+1)+j.
REQ-009 dir_rd_data  input  2  direction code, valid exactly 1 cycle after dir_rd_en.
REQ-010 op_valid  output  1  alignment-op output valid.
REQ-011 op_code  output  2  01 diag, 10 up (gap in B), 11 left (gap in A).
REQ-012 op_ready  input  1  downstream accepts op when high with op_valid.
REQ-013 ftraceback  output  1  phase-done flag returned to the sequencer.

Function
REQ-014 SHALL implement states IDLE, READ, WAIT, EMIT, DONE.
REQ-015 IDLE: on traceback_n==0, load i=ROWS, j=COLS, go READ.
REQ-016 READ: dir_rd_en=1 for exactly one cycle with address of (i,j); go WAIT.
REQ-017 WAIT: register dir_rd_data; code 00 -> DONE; else go EMIT.
REQ-018 Override: i==0 forces code 11; j==0 forces code 10, regardless of memory data.
REQ-019 i==0 and j==0 on entering READ -> go DONE directly, no read issued.
REQ-020 EMIT: op_valid=1, op_code held stable until op_valid&&op_ready.
REQ-021 On handshake: 01 -> i--,j--; 10 -> i--; 11 -> j--; then go READ.
REQ-022 Throughput: one op per 3 cycles when op_ready is constantly high.
REQ-023 DONE: ftraceback=1, held while traceback_n==0; traceback_n==1 -> IDLE, ftraceback=0 next cycle.
REQ-024 traceback_n==1 in READ/WAIT/EMIT -> abort to IDLE next cycle; op_valid drops; ftraceback never asserted.
REQ-025 i, j SHALL never underflow; total ops <= ROWS+COLS.

Reset
REQ-026 On reset: state IDLE, i=j=0, dir_rd_en=0, dir_rd_addr=0, op_valid=0, op_code=00, ftraceback=0.
REQ-027 Reset mid-operation discards pending op; restart requires traceback_n low after reset release.

Configuration
REQ-028 With TB_STATS_EN defined: outputs n_diag, n_up, n_left, each clog2(ROWS+COLS+1) bits, count accepted ops, cleared on IDLE->READ entry and on reset, stable in DONE.
REQ-029 Without TB_STATS_EN: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-030 Shared package dna_pkg SHALL hold dir_t (STOP=00, DIAG=01, UP=10, LEFT=11) and the state enum tb_state_t.
REQ-031 Counters SHALL sit in sub-module tb_stats_cnt, instantiated only under TB_STATS_EN.

Verification
REQ-032 ROWS=COLS=4, memory all DIAG, op_ready=1 -> ops 01,01,01,01, then ftraceback=1; addresses 24,18,12,6.
REQ-033 ROWS=2,COLS=3, (2,3)=LEFT,(2,2)=UP,(1,2)=DIAG,(0,1) forced -> ops 11,10,01,11, ftraceback=1.
REQ-034 STOP at (3,3) on first read -> zero ops, ftraceback=1 at cycle 3 after traceback_n falls.
REQ-035 op_ready low 5 cycles in EMIT -> op_valid and op_code stable 5 cycles, no coordinate change.
REQ-036 traceback_n raised during EMIT -> op_valid=0 next cycle, ftraceback stays 0; reset asserted mid-READ -> all outputs at reset values immediately.
REQ-037 TB_STATS_EN with REQ-033 stimulus -> n_diag=1, n_up=1, n_left=2 in DONE.
